// File: rtl/morse_pkg.sv
// morse_pkg: Morse symbol type, FSM states and ASCII-to-pattern lookup
package morse_pkg;

   typedef struct packed {
      logic [2:0] len;
      logic [4:0] bits;
   } morse_sym_t;

   typedef enum logic [2:0] {S_IDLE, S_ON, S_GAP, S_CGAP, S_WORD} state_t;

   // Element bits are LSB first, 1 = dash
   localparam morse_sym_t LETTERS [26] = '{
      {3'd2, 5'b00010}, {3'd4, 5'b00001}, {3'd4, 5'b00101}, {3'd3, 5'b00001},
      {3'd1, 5'b00000}, {3'd4, 5'b00100}, {3'd3, 5'b00011}, {3'd4, 5'b00000},
      {3'd2, 5'b00000}, {3'd4, 5'b01110}, {3'd3, 5'b00101}, {3'd4, 5'b00010},
      {3'd2, 5'b00011}, {3'd2, 5'b00001}, {3'd3, 5'b00111}, {3'd4, 5'b00110},
      {3'd4, 5'b01011}, {3'd3, 5'b00010}, {3'd3, 5'b00000}, {3'd1, 5'b00001},
      {3'd3, 5'b00100}, {3'd4, 5'b01000}, {3'd3, 5'b00110}, {3'd4, 5'b01001},
      {3'd4, 5'b01101}, {3'd4, 5'b00011}
   };

   function automatic morse_sym_t morse_lookup(input logic [7:0] ascii);
      logic [7:0] c;
      logic [3:0] d;
      c = (ascii >= 8'h61 && ascii <= 8'h7a) ? ascii - 8'h20 : ascii;
      d = c[3:0];
      if (c >= 8'h41 && c <= 8'h5a) return LETTERS[5'(c - 8'h41)];
      // Digits: 1-5 start with dots, 6-9 start with dashes, 0 is all dashes
      if (c >= 8'h30 && c <= 8'h39)
         return {3'd5, d == 4'd0 ? 5'b11111 : d <= 4'd5 ? 5'b11111 << d : 5'b11111 >> (4'd10 - d)};
      return '0;
   endfunction

endpackage

// File: rtl/morse_led_unit_timer.sv
// unit_timer: counts 0..UNIT_CYCLES-1, pulses unit_tick on the last count
module unit_timer #(
   parameter int UNIT_CYCLES = 1_600_000
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic restart,
   output logic unit_tick
);
   localparam int W = $clog2(UNIT_CYCLES);

   logic [W-1:0] cnt_q, cnt_d;

   assign unit_tick = cnt_q == W'(UNIT_CYCLES - 1);

   always_comb cnt_d = (restart || unit_tick) ? '0 : cnt_q + 1'b1;

   always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) cnt_q <= '0;
      else cnt_q <= cnt_d;

endmodule

// File: rtl/morse_led.sv
// morse_led: plays one ASCII character at a time as Morse code on LED
module morse_led
   import morse_pkg::*;
#(
   parameter int UNIT_CYCLES = 1_600_000
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       char_valid,
   input  logic [7:0] char_data,
   output logic       char_ready,
   output logic       busy,
   output logic       LED
);
   state_t     state_q, state_d;
   logic [4:0] bits_q, bits_d;
   logic [2:0] len_q, len_d;
   logic [2:0] units_q, units_d;
   logic [2:0] dur;
   logic       tick, done, restart;
   morse_sym_t sym;

   unit_timer #(.UNIT_CYCLES(UNIT_CYCLES)) u_timer (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .restart  (restart),
      .unit_tick(tick)
   );

   assign char_ready = state_q == S_IDLE;
   assign busy       = state_q != S_IDLE;
   assign LED        = state_q == S_ON;

   always_comb begin
      state_d = state_q;
      bits_d  = bits_q;
      len_d   = len_q;
      sym     = morse_lookup(char_data);
      dur     = state_q == S_ON   ? (bits_q[0] ? 3'd3 : 3'd1) :
                state_q == S_GAP  ? 3'd1 :
                state_q == S_CGAP ? 3'd3 : 3'd7;
      done    = tick && units_q == dur - 3'd1;
      case (state_q)
         S_IDLE:
            if (char_valid) begin
               bits_d  = sym.bits;
               len_d   = sym.len;
               state_d = sym.len == 3'd0 ? S_WORD : S_ON;
            end
         S_ON:
            if (done) begin
               bits_d  = bits_q >> 1;
               len_d   = len_q - 3'd1;
               state_d = len_q == 3'd1 ? S_CGAP : S_GAP;
            end
         S_GAP:   if (done) state_d = S_ON;
         default: if (done) state_d = S_IDLE;
      endcase
      // Timer and unit counter restart on every state entry and idle in IDLE
      restart = state_q == S_IDLE || state_d != state_q;
      units_d = state_d != state_q ? '0 : units_q + {2'b0, tick};
   end

   always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) begin
         state_q <= S_IDLE;
         bits_q  <= '0;
         len_q   <= '0;
         units_q <= '0;
      end else begin
         state_q <= state_d;
         bits_q  <= bits_d;
         len_q   <= len_d;
         units_q <= units_d;
      end

endmodule

// File: tb/tb_morse_led.sv
// tb_morse_led: directed checks of Morse timing with UNIT_CYCLES = 4
module tb_morse_led;
   logic       CLK = 1'b0;
   logic       RST_N = 1'b0;
   logic       char_valid = 1'b0;
   logic [7:0] char_data = 8'h00;
   logic       char_ready, busy, LED;
   int         n_cmp = 0;
   int         n_err = 0;
   logic       led_tr [1:128];
   logic       rdy_tr [1:128];
   logic       busy_tr[1:128];

   morse_led #(.UNIT_CYCLES(4)) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .char_valid(char_valid),
      .char_data (char_data),
      .char_ready(char_ready),
      .busy      (busy),
      .LED       (LED)
   );

   always #5 CLK = ~CLK;

   // Handshake at the end of cycle k; returns 1 ns into cycle k+1
   task automatic send(input logic [7:0] c);
      @(negedge CLK);
      char_data  = c;
      char_valid = 1'b1;
      @(posedge CLK);
      #1 char_valid = 1'b0;
   endtask

   // Records outputs for cycles k+1..k+n
   task automatic capture(input int n);
      for (int i = 1; i <= n; i++) begin
         led_tr[i]  = LED;
         rdy_tr[i]  = char_ready;
         busy_tr[i] = busy;
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic test_reset;
      #1;
      n_cmp += 3;
      if (LED !== 1'b0)        begin n_err++; $display("FAIL reset LED=%b want 0", LED); end
      if (char_ready !== 1'b1) begin n_err++; $display("FAIL reset char_ready=%b want 1", char_ready); end
      if (busy !== 1'b0)       begin n_err++; $display("FAIL reset busy=%b want 0", busy); end
      repeat (2) @(posedge CLK);
      @(negedge CLK) RST_N = 1'b1;
      @(posedge CLK);
      #1;
   endtask

   task automatic test_e(input string name);
      logic el, er;
      send(8'h45);
      capture(17);
      for (int i = 1; i <= 17; i++) begin
         el = i <= 4;
         er = i == 17;
         n_cmp += 2;
         if (led_tr[i] !== el) begin n_err++; $display("FAIL %s cyc %0d LED=%b want %b", name, i, led_tr[i], el); end
         if (rdy_tr[i] !== er) begin n_err++; $display("FAIL %s cyc %0d ready=%b want %b", name, i, rdy_tr[i], er); end
      end
   endtask

   task automatic test_s_lower;
      logic el, er;
      send(8'h73);
      capture(33);
      for (int i = 1; i <= 33; i++) begin
         el = i inside {[1:4], [9:12], [17:20]};
         er = i == 33;
         n_cmp += 2;
         if (led_tr[i] !== el) begin n_err++; $display("FAIL s cyc %0d LED=%b want %b", i, led_tr[i], el); end
         if (rdy_tr[i] !== er) begin n_err++; $display("FAIL s cyc %0d ready=%b want %b", i, rdy_tr[i], er); end
      end
   endtask

   task automatic test_back_to_back;
      logic el, er;
      @(negedge CLK);
      char_data  = 8'h54;
      char_valid = 1'b1;
      @(posedge CLK);
      #1 char_data = 8'h45;
      for (int i = 1; i <= 42; i++) begin
         el = i inside {[1:12], [26:29]};
         er = i == 25 || i == 42;
         n_cmp += 2;
         if (LED !== el)        begin n_err++; $display("FAIL b2b cyc %0d LED=%b want %b", i, LED, el); end
         if (char_ready !== er) begin n_err++; $display("FAIL b2b cyc %0d ready=%b want %b", i, char_ready, er); end
         if (i == 26) char_valid = 1'b0;
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic test_zero_toggle;
      logic el, eb;
      send(8'h30);
      char_data = 8'h45;
      for (int i = 1; i <= 89; i++) begin
         el = i inside {[1:12], [17:28], [33:44], [49:60], [65:76]};
         eb = i <= 88;
         n_cmp += 2;
         if (LED !== el)  begin n_err++; $display("FAIL zero cyc %0d LED=%b want %b", i, LED, el); end
         if (busy !== eb) begin n_err++; $display("FAIL zero cyc %0d busy=%b want %b", i, busy, eb); end
         char_valid = i < 85 ? i[0] : 1'b0;
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic test_space(input logic [7:0] c);
      logic eb, er;
      send(c);
      capture(29);
      for (int i = 1; i <= 29; i++) begin
         eb = i <= 28;
         er = i == 29;
         n_cmp += 3;
         if (led_tr[i] !== 1'b0) begin n_err++; $display("FAIL space %h cyc %0d LED=%b want 0", c, i, led_tr[i]); end
         if (busy_tr[i] !== eb)  begin n_err++; $display("FAIL space %h cyc %0d busy=%b want %b", c, i, busy_tr[i], eb); end
         if (rdy_tr[i] !== er)   begin n_err++; $display("FAIL space %h cyc %0d ready=%b want %b", c, i, rdy_tr[i], er); end
      end
   endtask

   task automatic test_async_reset;
      send(8'h53);
      capture(9);
      n_cmp++;
      if (LED !== 1'b1) begin n_err++; $display("FAIL arst pre LED=%b want 1", LED); end
      #2 RST_N = 1'b0;
      #1;
      n_cmp += 3;
      if (LED !== 1'b0)        begin n_err++; $display("FAIL arst LED=%b want 0", LED); end
      if (char_ready !== 1'b1) begin n_err++; $display("FAIL arst char_ready=%b want 1", char_ready); end
      if (busy !== 1'b0)       begin n_err++; $display("FAIL arst busy=%b want 0", busy); end
      @(negedge CLK) RST_N = 1'b1;
      @(posedge CLK);
      #1;
      n_cmp += 2;
      if (char_ready !== 1'b1) begin n_err++; $display("FAIL arst post ready=%b want 1", char_ready); end
      if (LED !== 1'b0)        begin n_err++; $display("FAIL arst post LED=%b want 0", LED); end
      test_e("e_after_rst");
   endtask

   initial begin
      test_reset;
      test_e("e");
      test_s_lower;
      test_back_to_back;
      test_zero_toggle;
      test_space(8'h20);
      test_space(8'h3f);
      test_async_reset;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/morse_led.md
# morse_led

Morse-code LED driver for the TinyFPGA BX user LED, sitting directly upstream of the board LED pin in place of a free-running divider bit. It accepts one ASCII character at a time over a valid/ready handshake, looks up its Morse pattern, and plays it on `LED` with standard Morse timing derived from a 16 MHz clock. A top level or a message-ROM sequencer feeds it characters. `USBPU` stays tied low at top level.

## Interface
- `UNIT_CYCLES`, default 1_600_000: clock cycles per Morse time unit (100 ms at 16 MHz); minimum 2.
- `CLK`  in  1  system clock, 16 MHz.
- `RST_N`  in  1  asynchronous, active-low reset.
- `char_valid`  in  1  character offered on `char_data`.
- `char_data`  in  8  ASCII character.
- `char_ready`  out  1  block can accept a character.
- `busy`  out  1  a character is being played, including its trailing gap.
- `LED`  out  1  LED drive, 1 = on.

## Operation
- Character set:
  - Letters A–Z; lowercase maps to uppercase.
  - Digits 0–9.
  - Space.
  - Any other code is treated as space.
- Element timing, in units:
  - Dot = 1 on; dash = 3 on.
  - Gap between elements of one character = 1 off.
  - Gap after the last element = 3 off (character gap).
  - Space = 7 off, no on time.
- States:
  - IDLE: `char_ready`=1, `busy`=0, `LED`=0. `char_valid && char_ready` loads the pattern. Go to ON, or WORD if space.
  - ON: `LED`=1 for 1 or 3 units. If elements remain, go to GAP; otherwise go to CGAP.
  - GAP: `LED`=0 for 1 unit, then ON with the next element.
  - CGAP: `LED`=0 for 3 units, then IDLE.
  - WORD: `LED`=0 for 7 units, then IDLE.
- `char_valid` is ignored outside IDLE. `char_data` is sampled only on the handshake cycle.
- A unit timer counts 0..`UNIT_CYCLES`-1 and pulses `unit_tick` on the last count. It restarts at 0 on every state entry. The per-state unit counter is 3 bits and counts up to 7.
- Pattern register: 5-bit element bits, LSB first, 1 = dash, plus a 3-bit remaining-element count (1..5). Both shift/decrement on each ON exit.
- Reset, including mid-character: state → IDLE, `LED`=0, `busy`=0, `char_ready`=1, counters cleared. Everything takes effect asynchronously on `RST_N` low. The in-flight character is discarded.

## Timing
- All outputs are registered or decoded from registered state. `char_ready` = (state == IDLE).
- With the handshake in cycle k, `LED` is 1 from cycle k+1.
- Each state lasts exactly N × `UNIT_CYCLES` cycles, with no extra transition cycles.
- Busy length per character = sum of its on and off units × `UNIT_CYCLES`. `char_ready` returns in the first cycle after the final gap.
- Maximum throughput is back-to-back characters with zero idle cycles, when `char_valid` is held high.
- Counter width is `$clog2(UNIT_CYCLES)`. The timer wraps only through explicit restart, never by overflow.

## Structure
- Package `morse_pkg`:
  - Typedef `morse_sym_t` {len[2:0], bits[4:0]}.
  - State enum.
  - Function `morse_lookup(ascii)` → `morse_sym_t`, with len 0 meaning space.
- Sub-module `unit_timer` (CLK, RST_N, restart, `unit_tick`), parameterised by `UNIT_CYCLES`.
- Top FSM and pattern register live in `morse_led`.

## Test plan
All scenarios use `UNIT_CYCLES`=4 and handshake in cycle k.
- 'E' (0x45) → `LED` high k+1..k+4; low 12 cycles; `char_ready` high at k+17.
- 'S' (0x73, lowercase) → three 4-cycle high pulses separated by 4 low; then 12 low; ready at k+33.
- 'T' then 'E' back-to-back with `char_valid` held → `LED` 12 high, 12 low; second handshake at k+25, whose `LED` high starts at k+26.
- '0' (five dashes) → five 12-cycle pulses, 4-cycle gaps, 12-cycle tail; `busy` for 88 cycles. `char_valid` toggling during play changes nothing.
- 0x20 and 0x3F ('?') → each: `LED` low, `busy` 28 cycles, ready at k+29.
- `RST_N` low during the second dot of 'S' → `LED` 0 in the same cycle, no clock edge needed. `char_ready`=1 after release. The next 'E' plays from scratch with nominal timing.
